// File: rtl/subband_ram_writer_pkg.sv
// Shared subband layout, FSM and sub_cycle encodings.
// Used by the subband coder and decoder RAM paths.
package subband_ram_writer_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] LL_BASE_ADDRESS = 12'd0;
  localparam logic [ADDR_W-1:0] HL_BASE_ADDRESS = 12'd32;
  localparam logic [ADDR_W-1:0] LH_BASE_ADDRESS = 12'd2048;

  localparam int COLS       = 16;
  localparam int ROWS       = 32;
  localparam int ROW_STRIDE = 64;

  localparam int PIXELS = COLS * ROWS;
  localparam int PIX_W  = $clog2(PIXELS);
  localparam int COL_W  = $clog2(COLS);

  // Offset step taken after the last pixel of a subband row.
  localparam logic [ADDR_W-1:0] ROW_JUMP =
    ADDR_W'(ROW_STRIDE - COLS + 1);

  localparam logic [COL_W-1:0] LAST_COL =
    COL_W'(COLS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX =
    PIX_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LL = 2'd0,
    HL = 2'd1,
    LH = 2'd2
  } sub_cycle_e;

  // Saturate a 16-bit signed value to the signed 12-bit range.
  function automatic logic [DATA_W-1:0] clamp12(
    input logic [DATA_W-1:0] x
  );
    logic signed [DATA_W-1:0] s;
    s = $signed(x);
    if (s > 16'sd2047)
      clamp12 = 16'h07FF;
    else if (s < -16'sd2048)
      clamp12 = 16'hF800;
    else
      clamp12 = x;
  endfunction

endpackage

// File: rtl/subband_ram_writer_addr_gen.sv
// Subband RAM address generator: offset/column/pixel/sub_cycle.
// clear, advance in; address = base[sub_cycle]+offset, last_flag out.
module subband_addr_gen
  import subband_ram_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] address,
  output logic              last_flag
);

  logic [ADDR_W-1:0] offset;
  logic [COL_W-1:0]  column;
  logic [PIX_W-1:0]  pixel;
  sub_cycle_e        sub_cycle;
  logic [ADDR_W-1:0] base;

  always_comb begin
    base = LL_BASE_ADDRESS;
    unique case (sub_cycle)
      LL:      base = LL_BASE_ADDRESS;
      HL:      base = HL_BASE_ADDRESS;
      LH:      base = LH_BASE_ADDRESS;
      default: base = LL_BASE_ADDRESS;
    endcase
  end

  assign address   = base + offset;
  assign last_flag = (pixel == LAST_PIX) &&
                     (sub_cycle == LH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset    <= '0;
      column    <= '0;
      pixel     <= '0;
      sub_cycle <= LL;
    end else if (clear || (advance && last_flag)) begin
      offset    <= '0;
      column    <= '0;
      pixel     <= '0;
      sub_cycle <= LL;
    end else if (advance) begin
      unique case (sub_cycle)
        LL: sub_cycle <= HL;
        HL: sub_cycle <= LH;
        LH: begin
          sub_cycle <= LL;
          pixel     <= pixel + 1'b1;
          if (column == LAST_COL) begin
            column <= '0;
            offset <= offset + ROW_JUMP;
          end else begin
            column <= column + 1'b1;
            offset <= offset + 1'b1;
          end
        end
        default: sub_cycle <= LL;
      endcase
    end
  end

endmodule

// File: rtl/subband_ram_writer.sv
// Scatters decoded LL/HL/LH coefficients into the coefficient RAM.
// Ports: start, coef_in/valid/ready in; ram_* writes, busy, done out.
// Build option SUBBAND_RAM_WRITER_CLAMP_EN saturates data to 12 bits.
module subband_ram_writer
  import subband_ram_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done
);

  state_e            state;
  logic              xfer;
  logic              start_ok;
  logic [ADDR_W-1:0] gen_addr;
  logic              last_flag;
  logic [DATA_W-1:0] wr_data;

  assign coef_ready = (state == WRITE);
  assign xfer       = coef_valid && coef_ready;
  assign start_ok   = start && (state == IDLE);

`ifdef SUBBAND_RAM_WRITER_CLAMP_EN
  assign wr_data = clamp12(coef_in);
`else
  assign wr_data = coef_in;
`endif

  subband_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .advance   (xfer),
    .address   (gen_addr),
    .last_flag (last_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ram_wren <= xfer;
      if (xfer) begin
        ram_address <= gen_addr;
        ram_data    <= wr_data;
      end
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= WRITE;
            busy  <= 1'b1;
          end
        end
        WRITE: begin
          if (xfer && last_flag) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subband_ram_writer.sv
// Directed bench for subband_ram_writer.
// Checks addresses, handshake, framing, reset and clamp behaviour.
module tb_subband_ram_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] coef_in = '0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [11:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int done_base;

  subband_ram_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .coef_in     (coef_in),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    coef_in    = d;
    coef_valid = 1'b1;
    tick();
  endtask

  task automatic chk_wr(
    input string       tag,
    input logic [11:0] a,
    input logic [15:0] d
  );
    chk({tag, "_wren"}, 32'(ram_wren), 32'd1);
    chk({tag, "_addr"}, 32'(ram_address), 32'(a));
    chk({tag, "_data"}, 32'(ram_data), 32'(d));
  endtask

  task automatic feed_pixel(input int p);
    send(16'(p));
    send(16'(p + 1));
    send(16'(p + 2));
  endtask

  logic [15:0] exp_hi;
  logic [15:0] exp_lo;

  initial begin
`ifdef SUBBAND_RAM_WRITER_CLAMP_EN
    exp_hi = 16'h07FF;
    exp_lo = 16'hF800;
`else
    exp_hi = 16'h7FFF;
    exp_lo = 16'h8000;
`endif
    tick();
    tick();
    chk("rst_ready", 32'(coef_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    rst_n = 1'b1;
    tick();

    // valid in IDLE is not accepted
    coef_valid = 1'b1;
    coef_in    = 16'h1234;
    tick();
    chk("idle_wren", 32'(ram_wren), 32'd0);
    chk("idle_ready", 32'(coef_ready), 32'd0);
    coef_valid = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(coef_ready), 32'd1);

    send(16'h0011);
    chk_wr("p0_ll", 12'd0, 16'h0011);
    send(16'h0022);
    chk_wr("p0_hl", 12'd32, 16'h0022);
    send(16'h0033);
    chk_wr("p0_lh", 12'd2048, 16'h0033);

    for (int p = 1; p < 15; p++) feed_pixel(p);

    send(16'h0151);
    chk_wr("p15_ll", 12'd15, 16'h0151);
    send(16'h0152);
    chk_wr("p15_hl", 12'd47, 16'h0152);
    send(16'h0153);
    chk_wr("p15_lh", 12'd2063, 16'h0153);

    send(16'h0161);
    chk_wr("p16_ll", 12'd64, 16'h0161);
    send(16'h0162);
    chk_wr("p16_hl", 12'd96, 16'h0162);
    send(16'h0163);
    chk_wr("p16_lh", 12'd2112, 16'h0163);

    // pixel 17 with a 5-cycle gap before LH
    send(16'h0171);
    chk_wr("p17_ll", 12'd65, 16'h0171);
    send(16'h0172);
    chk_wr("p17_hl", 12'd97, 16'h0172);
    coef_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("gap_wren", 32'(ram_wren), 32'd0);
    end
    send(16'h0173);
    chk_wr("p17_lh", 12'd2113, 16'h0173);

    done_base = done_cnt;
    for (int p = 18; p < 511; p++) begin
      if (p == 200) start = 1'b1;
      feed_pixel(p);
      if (p == 200) begin
        start = 1'b0;
        chk("mid_start_busy", 32'(busy), 32'd1);
      end
    end
    chk("pre_last_done", 32'(done_cnt - done_base), 32'd0);

    send(16'h0511);
    chk_wr("p511_ll", 12'd1999, 16'h0511);
    send(16'h0512);
    chk_wr("p511_hl", 12'd2031, 16'h0512);
    send(16'h0513);
    chk_wr("p511_lh", 12'd4047, 16'h0513);
    chk("last_done", 32'(done), 32'd1);
    chk("last_busy", 32'(busy), 32'd1);
    chk("last_ready", 32'(coef_ready), 32'd0);

    // start coincident with done is dropped
    coef_valid = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_wren", 32'(ram_wren), 32'd0);
    tick();
    chk("ign_start_busy", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_cnt - done_base), 32'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    send(16'h0AAA);
    chk_wr("f2_ll", 12'd0, 16'h0AAA);
    send(16'h7FFF);
    chk_wr("clamp_hi", 12'd32, exp_hi);
    send(16'h8000);
    chk_wr("clamp_lo", 12'd2048, exp_lo);

    // asynchronous abort with a transfer pending
    coef_in = 16'h0BBB;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(coef_ready), 32'd0);
    chk("abort_wren", 32'(ram_wren), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr", 32'(ram_address), 32'd0);
    tick();
    chk("abort_nowr", 32'(ram_wren), 32'd0);
    coef_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("abort_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
